// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through read port,
// fill level, full/empty/almost-full status and a sticky overflow flag for dropped bytes.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [7:0]        rx_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_LVL = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic              overflow_r;

  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Handshake decode; a push into a full FIFO is accepted only if the head leaves in the same cycle
  always_comb begin
    empty_s = (level_r == '0);
    full_s  = (level_r == FULL_LVL);
    pop_s   = !empty_s && rd_ready;
    push_s  = rx_dv && (!full_s || pop_s);
    drop_s  = rx_dv && full_s && !pop_s;
  end

  // Storage array, cleared on reset so the head byte is never undefined
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // Pointers, occupancy and sticky overflow (a new drop wins over a clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign rd_data     = mem_r[rd_ptr_r];
  assign rd_valid    = !empty_s;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (level_r >= AFULL_LVL);
  assign level       = level_r;
  assign overflow    = overflow_r;

endmodule
